// File: rtl/spi_slv_pkg.sv
// Shared opcodes and FSM encoding for the SPI mode-0 RAM target.
package spi_slv_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDID  = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_ID,
        ST_IGN
    } state_t;

endpackage

// File: rtl/spi_slv_ram_sync_2ff.sv
// Two-flop synchronizer bank with a configurable reset value per bit.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slv_ram.sv
// SPI mode-0 target with byte RAM: READ (03), WRITE (02), RDID (9F), all
// oversampled in the clk domain. peek port reads the RAM combinationally.
//
// state   | meaning
// IDLE    | waiting for a fresh CS falling edge
// CMD     | shifting in the opcode byte
// ADDR    | shifting in the address byte (read or write pending)
// RD      | streaming RAM bytes out, address auto-increments
// WR      | committing received bytes to RAM, address auto-increments
// ID      | streaming JEDEC ID bytes, then zeros
// IGN     | unknown opcode, MISO held low until CS rises
module spi_slv_ram
    import spi_slv_pkg::*;
#(
    parameter int          AW       = 8,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_cs,
    input  logic          spi_clk,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic [AW-1:0] peek_addr,
    output logic [7:0]    peek_data
);

    logic [2:0]    sync_q;
    logic [2:0]    sync_h;
    logic          cs_s, sck_s, cs_h, sck_h, mosi_h;
    logic          sck_rise, sck_fall, cs_rise, cs_fall;
    logic          armed;
    logic [1:0]    flush_cnt;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    rx_sh, rx_nxt, rx_byte;
    logic [7:0]    tx_sh, tx_nxt;
    logic [AW-1:0] addr, addr_nxt, rx_addr;
    logic [1:0]    id_idx, id_nxt;
    logic          rd_flag, rd_nxt;
    logic          byte_done;
    logic          mem_we;

    logic [7:0]    mem [2**AW];

    sync_2ff #(
        .WIDTH   (3),
        .RST_VAL (3'b001)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({spi_mosi, spi_clk, spi_cs}),
        .q     (sync_q)
    );

    assign cs_s   = sync_q[0];
    assign sck_s  = sync_q[1];
    assign cs_h   = sync_h[0];
    assign sck_h  = sync_h[1];
    assign mosi_h = sync_h[2];

    assign sck_rise = sck_s & ~sck_h;
    assign sck_fall = ~sck_s & sck_h;
    assign cs_rise  = cs_s & ~cs_h;
    // A CS already low when reset releases must not start a transaction.
    assign cs_fall  = ~cs_s & cs_h & armed;

    assign rx_byte = {rx_sh[6:0], mosi_h};
    assign rx_addr = AW'(rx_byte);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        rx_nxt    = rx_sh;
        tx_nxt    = tx_sh;
        addr_nxt  = addr;
        id_nxt    = id_idx;
        rd_nxt    = rd_flag;
        byte_done = 1'b0;
        mem_we    = 1'b0;

        if (cs_rise) begin
            state_nxt = ST_IDLE;
            bit_nxt   = 3'd0;
            tx_nxt    = 8'h00;
        end else if (cs_fall && state == ST_IDLE) begin
            state_nxt = ST_CMD;
            bit_nxt   = 3'd0;
            tx_nxt    = 8'h00;
        end else if (state != ST_IDLE) begin
            // No shift at bit 0 so a freshly loaded MSB survives to the next rise.
            if (sck_fall && bit_cnt != 3'd0) begin
                tx_nxt = {tx_sh[6:0], 1'b0};
            end
            if (sck_rise) begin
                rx_nxt    = rx_byte;
                bit_nxt   = bit_cnt + 3'd1;
                byte_done = (bit_cnt == 3'd7);
            end

            if (byte_done) begin
                case (state)
                    ST_CMD: begin
                        case (rx_byte)
                            CMD_READ: begin
                                state_nxt = ST_ADDR;
                                rd_nxt    = 1'b1;
                            end
                            CMD_WRITE: begin
                                state_nxt = ST_ADDR;
                                rd_nxt    = 1'b0;
                            end
                            CMD_RDID: begin
                                state_nxt = ST_ID;
                                tx_nxt    = JEDEC_ID[23:16];
                                id_nxt    = 2'd1;
                            end
                            default: state_nxt = ST_IGN;
                        endcase
                    end
                    ST_ADDR: begin
                        if (rd_flag) begin
                            state_nxt = ST_RD;
                            tx_nxt    = mem[rx_addr];
                            addr_nxt  = rx_addr + AW'(1);
                        end else begin
                            state_nxt = ST_WR;
                            tx_nxt    = 8'h00;
                            addr_nxt  = rx_addr;
                        end
                    end
                    ST_RD: begin
                        tx_nxt   = mem[addr];
                        addr_nxt = addr + AW'(1);
                    end
                    ST_WR: begin
                        mem_we   = 1'b1;
                        tx_nxt   = 8'h00;
                        addr_nxt = addr + AW'(1);
                    end
                    ST_ID: begin
                        case (id_idx)
                            2'd1: begin
                                tx_nxt = JEDEC_ID[15:8];
                                id_nxt = 2'd2;
                            end
                            2'd2: begin
                                tx_nxt = JEDEC_ID[7:0];
                                id_nxt = 2'd3;
                            end
                            default: tx_nxt = 8'h00;
                        endcase
                    end
                    ST_IGN:  tx_nxt = 8'h00;
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_h    <= 3'b001;
            armed     <= 1'b0;
            flush_cnt <= 2'd2;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            addr      <= '0;
            id_idx    <= 2'd0;
            rd_flag   <= 1'b0;
        end else begin
            sync_h <= sync_q;
            if (flush_cnt != 2'd0) begin
                flush_cnt <= flush_cnt - 2'd1;
            end else if (cs_s) begin
                armed <= 1'b1;
            end
            bit_cnt <= bit_nxt;
            rx_sh   <= rx_nxt;
            tx_sh   <= tx_nxt;
            addr    <= addr_nxt;
            id_idx  <= id_nxt;
            rd_flag <= rd_nxt;
        end
    end

    // RAM deliberately has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= rx_byte;
        end
    end

    assign spi_miso    = tx_sh[7];
    assign spi_miso_oe = ~cs_s;
    assign peek_data   = mem[peek_addr];

endmodule

// File: tb/tb_spi_slv_ram.sv
// Randomized bench for spi_slv_ram against a transaction-level RAM/ID model.
module tb_spi_slv_ram;

    localparam int          HP  = 5;
    localparam logic [23:0] JID = 24'hEF4018;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] peek_addr = 8'h00;
    logic [7:0] peek_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];
    logic [23:0] jid_v = JID;

    spi_slv_ram #(.AW(8), .JEDEC_ID(JID)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_cs      (spi_cs),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .peek_addr   (peek_addr),
        .peek_data   (peek_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic q_add(input logic [7:0] b);
        tx_q.push_back(b);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = b[7-i];
            clk_wait(HP);
            r = {r[6:0], spi_miso};
            spi_clk = 1'b1;
            clk_wait(HP);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        clk_wait(HP + 1);
    endtask

    task automatic cs_high();
        clk_wait(HP);
        spi_cs = 1'b1;
        clk_wait(HP + 3);
    endtask

    // Expected MISO per byte and RAM side effects of one complete transaction.
    task automatic model_txn();
        logic [7:0] cmd, a, idx, e;
        exp_q.delete();
        cmd = tx_q[0];
        a   = (tx_q.size() > 1) ? tx_q[1] : 8'h00;
        for (int i = 0; i < tx_q.size(); i++) begin
            e   = 8'h00;
            idx = a + 8'(i - 2);
            if (cmd == 8'h03 && i >= 2) e = ref_mem[idx];
            if (cmd == 8'h02 && i >= 2) ref_mem[idx] = tx_q[i];
            if (cmd == 8'h9F && i >= 1 && i <= 3) e = jid_v[(3-i)*8 +: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_q(input string tag);
        logic [7:0] r;
        foreach (tx_q[i]) begin
            xfer_bits(tx_q[i], 8, r);
            chk($sformatf("%s_miso[%0d]", tag, i), r, exp_q[i]);
        end
    endtask

    task automatic run_txn(input string tag);
        model_txn();
        cs_low();
        send_q(tag);
        cs_high();
        tx_q.delete();
    endtask

    task automatic peek_chk(input logic [7:0] a);
        peek_addr = a;
        #1;
        chk($sformatf("peek_%02h", a), peek_data, ref_mem[a]);
    endtask

    task automatic peek_sweep();
        for (int a = 0; a < 256; a++) peek_chk(8'(a));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int n;

        clk_wait(3);
        chk("rst_miso", spi_miso, 1'b0);
        chk("rst_oe", spi_miso_oe, 1'b0);
        rst_n = 1'b1;
        clk_wait(6);

        // Fill the whole RAM so every later peek has a known value.
        q_add(8'h02); q_add(8'h00);
        for (int i = 0; i < 256; i++) q_add(8'($urandom));
        run_txn("fill");
        peek_sweep();

        q_add(8'h02); q_add(8'h10); q_add(8'hAA); q_add(8'h55);
        run_txn("wr10");
        peek_chk(8'h10);
        peek_chk(8'h11);
        chk("const_10", ref_mem[8'h10], 8'hAA);

        q_add(8'h03); q_add(8'h10); q_add(8'($urandom)); q_add(8'($urandom));
        run_txn("rd10");

        q_add(8'h9F);
        for (int i = 0; i < 4; i++) q_add(8'($urandom));
        model_txn();
        chk("id_oe_idle", spi_miso_oe, 1'b0);
        cs_low();
        chk("id_oe_sel", spi_miso_oe, 1'b1);
        send_q("rdid");
        cs_high();
        tx_q.delete();
        chk("id_oe_end", spi_miso_oe, 1'b0);

        q_add(8'h02); q_add(8'hFF); q_add(8'h11); q_add(8'h22);
        run_txn("wrwrap");
        peek_chk(8'hFF);
        peek_chk(8'h00);
        q_add(8'h03); q_add(8'hFF); q_add(8'h00); q_add(8'h00);
        run_txn("rdwrap");

        // Abort: partial fourth byte must not reach RAM.
        q_add(8'h02); q_add(8'h20); q_add(8'h12);
        model_txn();
        cs_low();
        send_q("abort");
        xfer_bits(8'hF0, 4, r);
        cs_high();
        tx_q.delete();
        peek_chk(8'h20);
        peek_chk(8'h21);
        q_add(8'h03); q_add(8'h20); q_add(8'h00); q_add(8'h00);
        run_txn("post_abort");

        q_add(8'hAB); q_add(8'h00); q_add(8'h00);
        run_txn("unk");
        peek_sweep();

        // Reset mid address byte of a read; CS left low must be ignored after.
        cs_low();
        xfer_bits(8'h03, 8, r);
        xfer_bits(8'h10, 4, r);
        chk("pre_rst_oe", spi_miso_oe, 1'b1);
        rst_n = 1'b0;
        clk_wait(1);
        chk("rst_mid_miso", spi_miso, 1'b0);
        chk("rst_mid_oe", spi_miso_oe, 1'b0);
        clk_wait(2);
        rst_n = 1'b1;
        clk_wait(8);
        xfer_bits(8'h9F, 8, r);
        chk("stale_cs_b0", r, 8'h00);
        xfer_bits(8'h00, 8, r);
        chk("stale_cs_b1", r, 8'h00);
        cs_high();
        q_add(8'h03); q_add(8'h10); q_add(8'h00);
        run_txn("post_rst");

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0: q_add(8'h03);
                1: q_add(8'h02);
                2: q_add(8'h9F);
                default: q_add(8'($urandom));
            endcase
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) q_add(8'($urandom));
            run_txn($sformatf("rnd%0d", t));
            peek_chk(8'($urandom));
        end
        peek_sweep();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
